// File: rtl/sample_feeder_if.sv
// ADC-side handshake plus filter-side strobe/data bundle for sample_feeder.
// master = the feeder itself, slave = its surroundings (ADC source and filter).
interface sample_feeder_if #(
  parameter int DATA_SIZE = 25
);
  logic [DATA_SIZE-2:0] adc_data;
  logic                 adc_valid;
  logic                 adc_ready;
  logic                 filter_done;
  logic [DATA_SIZE-2:0] data_in;
  logic                 sample;
  logic                 underrun;
  logic                 overrun;
  logic                 late_tick;

  modport master (
    input  adc_data, adc_valid, filter_done,
    output adc_ready, data_in, sample, underrun, overrun, late_tick
  );

  modport slave (
    output adc_data, adc_valid, filter_done,
    input  adc_ready, data_in, sample, underrun, overrun, late_tick
  );
endinterface

// File: rtl/sample_feeder.sv
// Buffers ADC words in a small FIFO and feeds one word per divider tick to the
// filter with a PULSE_W-cycle strobe, then waits for the filter's done strobe.
module sample_feeder #(
  parameter int DATA_SIZE  = 25,
  parameter int DIV        = 25000,
  parameter int PULSE_W    = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  sample_feeder_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DIV);
  localparam int PW = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;

  typedef enum logic [1:0] {IDLE, PULSE, WAIT_DONE} state_t;

  state_t               state_reg;
  logic [CW-1:0]        div_cnt_reg;
  logic [PW-1:0]        pulse_cnt_reg;
  logic                 done_reg;
  logic                 sample_reg;
  logic                 underrun_reg;
  logic                 overrun_reg;
  logic                 late_tick_reg;
  logic [DATA_SIZE-2:0] data_in_reg;
  logic [AW:0]          wr_ptr_reg;
  logic [AW:0]          rd_ptr_reg;
  logic [DATA_SIZE-2:0] mem [FIFO_DEPTH];
  logic                 tick;
  logic                 full;
  logic                 empty;
  logic                 wr_en;
  logic                 pop;

  assign tick  = (div_cnt_reg == CW'(DIV - 1));
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  // Extra pointer bit tells a full ring from an empty one when the indices match.
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign wr_en = bus.adc_valid && !full;
  assign pop   = (state_reg == IDLE) && tick && !empty;

  assign bus.adc_ready = !full;
  assign bus.data_in   = data_in_reg;
  assign bus.sample    = sample_reg;
  assign bus.underrun  = underrun_reg;
  assign bus.overrun   = overrun_reg;
  assign bus.late_tick = late_tick_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_reg <= '0;
    end else if (tick) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_reg + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (pop)   rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg[AW-1:0]] <= bus.adc_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      pulse_cnt_reg <= '0;
      done_reg      <= 1'b0;
      sample_reg    <= 1'b0;
      data_in_reg   <= '0;
      underrun_reg  <= 1'b0;
      overrun_reg   <= 1'b0;
      late_tick_reg <= 1'b0;
    end else begin
      underrun_reg  <= 1'b0;
      overrun_reg   <= bus.adc_valid && full;
      late_tick_reg <= tick && (state_reg != IDLE);
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (tick) begin
            // An empty FIFO still strobes the filter so its rate never slips.
            sample_reg    <= 1'b1;
            pulse_cnt_reg <= '0;
            state_reg     <= PULSE;
            if (empty) underrun_reg <= 1'b1;
            else       data_in_reg  <= mem[rd_ptr_reg[AW-1:0]];
          end
        end
        PULSE: begin
          if (bus.filter_done) done_reg <= 1'b1;
          if (pulse_cnt_reg == PW'(PULSE_W - 1)) begin
            sample_reg <= 1'b0;
            state_reg  <= WAIT_DONE;
          end else begin
            pulse_cnt_reg <= pulse_cnt_reg + PW'(1);
          end
        end
        WAIT_DONE: begin
          if (bus.filter_done || done_reg) begin
            done_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule
